// File: rtl/dcm_reset_sequencer.sv
// DCM reset/lock sequencer: pulses DCM RST, waits for a stable LOCKED, then releases core reset.
// Optional macro CLKIN_STOP_DETECT_EN adds the inStatus port and treats CLKIN-stopped as a lock loss.
module dcm_reset_sequencer #(
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             inClock,
  input  logic             inReset,
  input  logic             locked,
`ifdef CLKIN_STOP_DETECT_EN
  input  logic [7:0]       inStatus,
`endif
  output logic             dcmReset,
  output logic             sysReset_n,
  output logic [CNT_W-1:0] relockCount,
  output logic             failed
);

  localparam int unsigned CYC_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CYC_MAX   = (CYC_MAX_A > STABLE_CYCLES) ? CYC_MAX_A : STABLE_CYCLES;
  localparam int          CYC_W     = $clog2(CYC_MAX + 1);
  localparam int          RTY_W     = $clog2(MAX_RETRIES + 1);

  localparam logic [CYC_W-1:0] CYC_ONE      = CYC_W'(1);
  localparam logic [CYC_W-1:0] RST_LAST     = CYC_W'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT - 1);
  localparam logic [CYC_W-1:0] STABLE_LAST  = CYC_W'(STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_ONE      = RTY_W'(1);
  localparam logic [RTY_W-1:0] RTY_LIMIT    = RTY_W'(MAX_RETRIES);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

  localparam logic [2:0] S_DCM_RST   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAIL      = 3'd4;

  logic             r_lock_meta;
  logic             r_lock_s;
  logic [2:0]       r_state;
  logic [CYC_W-1:0] r_cyc_cnt;
  logic [RTY_W-1:0] r_retry_cnt;
  logic [CNT_W-1:0] r_relock_cnt;
  logic             r_dcm_reset;
  logic             r_sys_reset_n;
  logic             r_failed;

  logic             w_lock_loss;
  logic [2:0]       w_state_nxt;
  logic [CYC_W-1:0] w_cyc_nxt;
  logic [RTY_W-1:0] w_retry_nxt;
  logic [RTY_W-1:0] w_retry_inc;
  logic             w_relock_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

`ifdef CLKIN_STOP_DETECT_EN
  logic r_stop_meta;
  logic r_stop_s;

  // STATUS[1] (CLKIN stopped) is asynchronous to inClock, same as LOCKED.
  always_ff @(posedge inClock) begin
    if (!inReset) begin
      r_stop_meta <= 1'b0;
      r_stop_s    <= 1'b0;
    end else begin
      r_stop_meta <= inStatus[1];
      r_stop_s    <= r_stop_meta;
    end
  end

  assign w_lock_loss = ~r_lock_s | r_stop_s;
`else
  assign w_lock_loss = ~r_lock_s;
`endif

  always_ff @(posedge inClock) begin
    if (!inReset) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= locked;
      r_lock_s    <= r_lock_meta;
    end
  end

  assign w_retry_inc = r_retry_cnt + RTY_ONE;

  always_comb begin
    w_state_nxt  = r_state;
    w_cyc_nxt    = r_cyc_cnt;
    w_retry_nxt  = r_retry_cnt;
    w_relock_inc = 1'b0;
    case (r_state)
      S_DCM_RST: begin
        if (r_cyc_cnt == RST_LAST) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cyc_nxt   = '0;
        end else begin
          w_cyc_nxt = r_cyc_cnt + CYC_ONE;
        end
      end
      S_WAIT_LOCK: begin
        // Lock is checked first so a lock arriving on the timeout cycle wins.
        if (r_lock_s) begin
          w_state_nxt = S_STABLE;
          w_cyc_nxt   = '0;
        end else if (r_cyc_cnt == TIMEOUT_LAST) begin
          w_cyc_nxt   = '0;
          w_retry_nxt = w_retry_inc;
          w_state_nxt = (w_retry_inc == RTY_LIMIT) ? S_FAIL : S_DCM_RST;
        end else begin
          w_cyc_nxt = r_cyc_cnt + CYC_ONE;
        end
      end
      S_STABLE: begin
        if (w_lock_loss) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cyc_nxt   = '0;
        end else if (r_cyc_cnt == STABLE_LAST) begin
          w_state_nxt = S_RUN;
          w_cyc_nxt   = '0;
          w_retry_nxt = '0;
        end else begin
          w_cyc_nxt = r_cyc_cnt + CYC_ONE;
        end
      end
      S_RUN: begin
        if (w_lock_loss) begin
          w_state_nxt  = S_DCM_RST;
          w_cyc_nxt    = '0;
          w_relock_inc = 1'b1;
        end
      end
      S_FAIL: begin
        w_state_nxt = S_FAIL;
      end
      default: begin
        w_state_nxt = S_DCM_RST;
        w_cyc_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge inClock) begin
    if (!inReset) begin
      r_state       <= S_DCM_RST;
      r_cyc_cnt     <= '0;
      r_retry_cnt   <= '0;
      r_relock_cnt  <= '0;
      r_dcm_reset   <= 1'b1;
      r_sys_reset_n <= 1'b0;
      r_failed      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cyc_cnt     <= w_cyc_nxt;
      r_retry_cnt   <= w_retry_nxt;
      r_dcm_reset   <= (w_state_nxt == S_DCM_RST);
      r_sys_reset_n <= (w_state_nxt == S_RUN);
      r_failed      <= (w_state_nxt == S_FAIL);
      if (w_relock_inc) begin
        r_relock_cnt <= sat_inc(r_relock_cnt);
      end
    end
  end

  assign dcmReset    = r_dcm_reset;
  assign sysReset_n  = r_sys_reset_n;
  assign relockCount = r_relock_cnt;
  assign failed      = r_failed;

endmodule
